// File: rtl/systolic_pe_v2.sv
// Output-stationary systolic MAC cell: forwards operands/tags east-south with 1-cycle latency,
// accumulates x*y (signed/unsigned, saturating or wrapping) and feeds a shiftable result chain.
module systolic_pe_v2 #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SAT_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_y,
    input  logic              i_valid,
    input  logic              i_clear,
    input  logic              i_last,
    output logic [DATA_W-1:0] o_x,
    output logic [DATA_W-1:0] o_y,
    output logic              o_valid,
    output logic              o_clear,
    output logic              o_last,
    input  logic              i_shift,
    input  logic [ACC_W-1:0]  i_res,
    input  logic              i_res_ovf,
    output logic [ACC_W-1:0]  o_res,
    output logic              o_res_ovf,
    output logic              o_done
);

    localparam int PW = 2 * DATA_W;

    if (ACC_W < PW) begin : g_width_check
        $error("systolic_pe_v2: ACC_W must be at least 2*DATA_W");
    end

    logic [DATA_W-1:0] x_q, y_q;
    logic              valid_q, clear_q, last_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  res_q;
    logic              res_ovf_q;
    logic              done_q;

    logic signed [PW-1:0] prod_s;
    logic        [PW-1:0] prod_u;
    logic [ACC_W-1:0]     prod_s_ext, prod_u_ext, prod_ext;
    logic [ACC_W-1:0]     base, sat_val;
    logic [ACC_W:0]       sum_ext;
    logic                 base_msb, prod_msb;
    logic                 beat_ovf;
    logic                 load_local;

    assign prod_s     = PW'($signed(i_x)) * PW'($signed(i_y));
    assign prod_u     = PW'(i_x) * PW'(i_y);
    assign prod_s_ext = ACC_W'(prod_s);
    assign prod_u_ext = ACC_W'(prod_u);
    assign prod_ext   = i_signed ? prod_s_ext : prod_u_ext;

    assign base = i_clear ? '0 : acc_q;

    // One guard bit makes the sum exact, so overflow is read straight off the top bits.
    assign base_msb = i_signed & base[ACC_W-1];
    assign prod_msb = i_signed & prod_ext[ACC_W-1];
    assign sum_ext  = {base_msb, base} + {prod_msb, prod_ext};
    assign beat_ovf = i_signed ? (sum_ext[ACC_W] ^ sum_ext[ACC_W-1]) : sum_ext[ACC_W];

    assign sat_val = !i_signed      ? {ACC_W{1'b1}} :
                     sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                      {1'b0, {(ACC_W-1){1'b1}}};

    assign acc_d      = ((SAT_EN != 0) && beat_ovf) ? sat_val : sum_ext[ACC_W-1:0];
    assign ovf_d      = beat_ovf | (~i_clear & ovf_q);
    assign load_local = i_valid & i_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            clear_q   <= 1'b0;
            last_q    <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (en) begin
            x_q     <= i_x;
            y_q     <= i_y;
            valid_q <= i_valid;
            clear_q <= i_clear;
            last_q  <= i_last;
            if (i_valid) begin
                acc_q <= acc_d;
                ovf_q <= ovf_d;
            end
            // A local result beats the chain; the upstream value is dropped in that cycle.
            if (load_local) begin
                res_q     <= acc_d;
                res_ovf_q <= ovf_d;
            end else if (i_shift) begin
                res_q     <= i_res;
                res_ovf_q <= i_res_ovf;
            end
            done_q <= load_local;
        end else begin
            done_q <= 1'b0;
        end
    end

    assign o_x       = x_q;
    assign o_y       = y_q;
    assign o_valid   = valid_q;
    assign o_clear   = clear_q;
    assign o_last    = last_q;
    assign o_res     = res_q;
    assign o_res_ovf = res_ovf_q;
    assign o_done    = done_q;

endmodule
